mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 5, cycles from request acceptance to response (legal range 1..15).
REQ-002 Parameter DEPTH_LINES, default 256, number of 64-bit lines stored.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  cache miss/writeback request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = line write (writeback), 0 = line read (fill).
REQ-008 req_addr  input  16  byte address; bits [2:0] ignored; line index = req_addr[10:3].
REQ-009 req_wdata  input  64  four 16-bit words, word 0 in bits [15:0].
REQ-010 resp_valid  output  1  one-cycle response strobe.
REQ-011 resp_rdata  output  64  line read data (reads); written data echoed (writes).
REQ-012 resp_err  output  1  address-range error flag, valid with resp_valid.

Function
REQ-013 FSM states: IDLE, WAIT, RESP; req_ready SHALL equal (state==IDLE) while reset is deasserted.
REQ-014 Handshake: request accepted on an edge where req_valid & req_ready; req_addr/req_we/req_wdata captured then; inputs ignored at all other times.
REQ-015 IDLE -> WAIT on acceptance, 4-bit counter loaded with LATENCY-1.
REQ-016 WAIT: counter decrements each edge; when counter==0, next edge enters RESP and commits a write to the line array on that same edge.
REQ-017 RESP: resp_valid=1 for exactly one cycle, then unconditional return to IDLE; no response backpressure.
REQ-018 Timing: accepted at edge k -> resp_valid high in the cycle following edge k+LATENCY; minimum request spacing LATENCY+2 edges.
REQ-019 resp_rdata SHALL hold the captured line value (read: array contents at commit edge; write: req_wdata) from RESP entry until the next RESP; 0 after reset.
REQ-020 Read of a never-written line returns undefined data; read after write to same line returns written data.
REQ-021 resp_valid and resp_err SHALL be 0 in all states except RESP.
REQ-022 req_valid asserted during WAIT/RESP SHALL be held by requester; responder never drops or double-accepts it.

Reset
REQ-023 While reset=0: state=IDLE, counter=0, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0.
REQ-024 Reset mid-operation aborts the transaction without response; a write not yet committed SHALL NOT modify the array.
REQ-025 Line array contents are not reset.
REQ-026 First acceptance possible on the first edge after reset deasserts.

Configuration
REQ-027 Macro MEM_RESPONDER_ADDR_CHECK_EN.
REQ-028 Defined: request with req_addr[15:11]!=0 completes with normal latency, resp_err=1, array untouched, resp_rdata=0.
REQ-029 Not defined: resp_err tied 0; upper address bits ignored (aliasing).

Structure
REQ-030 Shared package mem_pkg: LINE_BITS=64, WORD_BITS=16, ADDR_BITS=16, state enum {IDLE,WAIT,RESP}.
REQ-031 One sub-module mem_line_array: DEPTH_LINES x 64 bits, synchronous write, combinational read.

Verification
REQ-032 Reset then write 0x0004_0003_0002_0001 to addr 0x0010, LATENCY=5 -> resp_valid one cycle after edge k+5, resp_rdata echoes data, resp_err=0.
REQ-033 Read addr 0x0017 after REQ-032 -> resp_rdata=0x0004_0003_0002_0001 (same line, low bits ignored).
REQ-034 req_valid held high continuously -> accepts exactly every LATENCY+2 edges, never during WAIT/RESP.
REQ-035 Assert reset during WAIT of a write to 0x0020 -> no resp_valid; subsequent read of 0x0020 does not return the aborted data.
REQ-036 With MEM_RESPONDER_ADDR_CHECK_EN, read 0x0800 -> resp_err=1, resp_rdata=0; without it -> aliases line 0, resp_err=0.
REQ-037 LATENCY=1 write then read same line -> each response one cycle after edge k+1, read returns written line.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths and FSM state type for mem_responder
package mem_pkg;
  localparam int WORD_BITS = 16;
  localparam int LINE_BITS = 4 * WORD_BITS;
  localparam int ADDR_BITS = 16;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/mem_line_array.sv
// mem_line_array: DEPTH_LINES x 64-bit storage, synchronous write, combinational read
module mem_line_array
  import mem_pkg::*;
#(
  parameter int DEPTH_LINES = 256
) (
  input  logic                           clk,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH_LINES)-1:0] addr_i,
  input  logic [LINE_BITS-1:0]           wdata_i,
  output logic [LINE_BITS-1:0]           rdata_o
);
  logic [LINE_BITS-1:0] mem_q [DEPTH_LINES];
  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency line memory responder; MEM_RESPONDER_ADDR_CHECK_EN flags req_addr[15:11]!=0
module mem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY     = 5,
  parameter int DEPTH_LINES = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [LINE_BITS-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [LINE_BITS-1:0] resp_rdata,
  output logic                 resp_err
);
  localparam int IW = $clog2(DEPTH_LINES);
  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [LINE_BITS-1:0] rdata_q, rdata_d, wdata_q, arr_rdata;
  logic [IW-1:0]        idx_q;
  logic                 we_q, err_q, accept, commit, addr_err, unused_addr;
  assign unused_addr = ^req_addr;
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
  assign addr_err = |req_addr[15:11];
`else
  assign addr_err = 1'b0;
`endif
  assign accept = (state_q == IDLE) && req_valid;
  assign commit = (state_q == WAIT) && (cnt_q == 4'd0);
  always_comb begin
    state_d = accept ? WAIT : commit ? RESP : (state_q == RESP) ? IDLE : state_q;
    cnt_d   = accept ? 4'(LATENCY - 1) : ((state_q == WAIT) && (cnt_q != 4'd0)) ? cnt_q - 4'd1 : cnt_q;
    rdata_d = !commit ? rdata_q : err_q ? '0 : we_q ? wdata_q : arr_rdata;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (accept) begin
        wdata_q <= req_wdata;
        idx_q   <= req_addr[3 +: IW];
        we_q    <= req_we;
        err_q   <= addr_err;
      end
    end
  end
  // the array only sees a write on the commit edge, so a reset before it leaves the line intact
  mem_line_array #(.DEPTH_LINES(DEPTH_LINES)) u_arr (
    .clk    (clk),
    .we_i   (commit && we_q && !err_q),
    .addr_i (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(arr_rdata)
  );
  assign req_ready  = (state_q == IDLE) && reset;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = rdata_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder at LATENCY 5 and 1
module tb_mem_responder;
  logic        clk = 1'b0, reset = 1'b0, v5 = 1'b0, v1 = 1'b0, req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rdy5, rv5, err5, rdy1, rv1, err1;
  logic [63:0] rd5, rd1;
  int checks = 0, errors = 0;
  localparam logic [63:0] A = 64'h0004_0003_0002_0001;
  localparam logic [63:0] B = 64'hdead_beef_cafe_f00d;
  localparam logic [63:0] C = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D = 64'h0a0b_0c0d_0e0f_1011;
  localparam logic [63:0] F = 64'h5555_aaaa_0f0f_f0f0;
  always #5 clk = ~clk;
  mem_responder #(.LATENCY(5)) u5 (
    .clk(clk), .reset(reset), .req_valid(v5), .req_ready(rdy5), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv5), .resp_rdata(rd5), .resp_err(err5)
  );
  mem_responder #(.LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1)
  );
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic txn(input bit s, input logic we, input logic [15:0] a, input logic [63:0] d,
                     input logic [63:0] ed, input logic ee, input string tag);
    int lat = s ? 1 : 5;
    req_we = we; req_addr = a; req_wdata = d;
    if (s) v1 = 1'b1; else v5 = 1'b1;
    #1 chk({tag, "_rdy_idle"}, s ? rdy1 : rdy5, 1'b1);
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0; v5 = 1'b0; req_addr = 16'hffff; req_wdata = '1; req_we = ~we;
    for (int j = 0; j <= lat; j++) begin
      #1 chk({tag, "_rv"}, s ? rv1 : rv5, j == lat);
      chk({tag, "_rdy_busy"}, s ? rdy1 : rdy5, 1'b0);
      if (j == lat) begin
        chk({tag, "_rdata"}, s ? rd1 : rd5, ed);
        chk({tag, "_err"}, s ? err1 : err5, ee);
      end else chk({tag, "_err_idle"}, s ? err1 : err5, 1'b0);
      @(negedge clk);
    end
    #1 chk({tag, "_rv_after"}, s ? rv1 : rv5, 1'b0);
    chk({tag, "_rdy_after"}, s ? rdy1 : rdy5, 1'b1);
    chk({tag, "_rdata_hold"}, s ? rd1 : rd5, ed);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rdy5", rdy5, 1'b0);
    chk("rst_rv5", rv5, 1'b0);
    chk("rst_err5", err5, 1'b0);
    chk("rst_rd5", rd5, 64'h0);
    chk("rst_rdy1", rdy1, 1'b0);
    chk("rst_rd1", rd1, 64'h0);
    reset = 1'b1;
    txn(0, 1'b1, 16'h0010, A, A, 1'b0, "wr10");
    txn(0, 1'b0, 16'h0017, '0, A, 1'b0, "rd17");
    req_we = 1'b0; req_addr = 16'h0010; v5 = 1'b1;
    for (int j = 0; j < 15; j++) begin
      #1 chk("hold_rdy", rdy5, j % 7 == 0);
      chk("hold_rv", rv5, j % 7 == 6);
      if (j % 7 == 6) chk("hold_rdata", rd5, A);
      if (j == 14) v5 = 1'b0; else @(negedge clk);
    end
    @(negedge clk);
    txn(0, 1'b1, 16'h0020, C, C, 1'b0, "wr20");
    req_we = 1'b1; req_addr = 16'h0020; req_wdata = B; v5 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v5 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("abort_rv", rv5, 1'b0);
    chk("abort_rdy", rdy5, 1'b0);
    chk("abort_rd", rd5, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      #1 chk("abort_no_resp", rv5, 1'b0);
    end
    txn(0, 1'b0, 16'h0020, '0, C, 1'b0, "rd20");
    txn(0, 1'b1, 16'h0000, D, D, 1'b0, "wr00");
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    txn(0, 1'b0, 16'h0800, '0, 64'h0, 1'b1, "rd800");
    txn(0, 1'b1, 16'h0800, F, 64'h0, 1'b1, "wr800");
    txn(0, 1'b0, 16'h0000, '0, D, 1'b0, "rd00");
`else
    txn(0, 1'b0, 16'h0800, '0, D, 1'b0, "rd800");
`endif
    txn(1, 1'b1, 16'h0018, F, F, 1'b0, "l1_wr18");
    txn(1, 1'b0, 16'h0018, '0, F, 1'b0, "l1_rd18");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
